// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback for a
// single-issue core, with a memory-wait watchdog and sticky trap causes.
module multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        R_type,
  input  logic        load,
  input  logic        I_type,
  input  logic        jalr,
  input  logic        S_type,
  input  logic        SB_type,
  input  logic        U_type,
  input  logic        UJ_type,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout,
  output logic        retire,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  // Count value on the last allowed wait cycle; no ready here means timeout.
  localparam logic [15:0] WaitLast = 16'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic [31:0] instret_q, instret_d;
  logic [15:0] wait_q, wait_d;
  logic [7:0]  flags;

  assign flags = {R_type, load, I_type, jalr, S_type, SB_type, U_type, UJ_type};

  // State and status registers; rst overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state logic; wait counter defaults to 0 so it is clear on entry to FETCH/MEM.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    wait_d    = '0;
    instret_d = instret_q + 32'(retire);
    case (state_q)
      StFetch: begin
        if (imem_ready) begin
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d   = StTrap;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StDecode: begin
        if ($onehot(flags)) begin
          state_d = StExec;
        end else begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end
      StExec: begin
        if (SB_type) begin
          state_d = StFetch;
        end else if (load || S_type) begin
          state_d = StMem;
        end else if (R_type || I_type || U_type || UJ_type || jalr) begin
          state_d = StWb;
        end else begin
          // Flags vanished after decode: treat as an illegal instruction.
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end
      StMem: begin
        if (dmem_ready) begin
          state_d = load ? StWb : StFetch;
        end else if (wait_q == WaitLast) begin
          state_d   = StTrap;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: begin
        state_d   = StTrap;
        illegal_d = 1'b1;
      end
    endcase
  end

  // Strobes and selects decoded from current state and inputs; all quiet under rst.
  always_comb begin
    imem_req = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    pc_sel   = 2'd0;
    wb_sel   = 2'd0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        StExec: begin
          if (SB_type) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            pc_sel = branch_taken ? 2'd1 : 2'd0;
          end
        end
        StMem: begin
          dmem_re = load;
          dmem_we = S_type && !load;
          if (dmem_ready && !load) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        StWb: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          if (UJ_type) pc_sel = 2'd2;
          else if (jalr) pc_sel = 2'd3;
          if (load) wb_sel = 2'd1;
          else if (UJ_type || jalr) wb_sel = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MAX_WAIT = 4).
module tb_multicycle_ctrl;

  localparam logic [7:0] FR  = 8'h80;
  localparam logic [7:0] FL  = 8'h40;
  localparam logic [7:0] FS  = 8'h08;
  localparam logic [7:0] FSB = 8'h04;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        R_type = 0, load = 0, I_type = 0, jalr = 0;
  logic        S_type = 0, SB_type = 0, U_type = 0, UJ_type = 0;
  logic        branch_taken = 0, imem_ready = 0, dmem_ready = 0;
  logic        imem_req, dmem_re, dmem_we, ir_we, rf_we, pc_we;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic        illegal, timeout, retire;
  logic [31:0] instret;
  logic [10:0] strb;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .R_type(R_type), .load(load), .I_type(I_type), .jalr(jalr),
    .S_type(S_type), .SB_type(SB_type), .U_type(U_type), .UJ_type(UJ_type),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .wb_sel(wb_sel), .state(state),
    .illegal(illegal), .timeout(timeout), .retire(retire), .instret(instret)
  );

  assign strb = {imem_req, dmem_re, dmem_we, ir_we, rf_we, pc_we, retire, pc_sel, wb_sel};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [7:0] f);
    {R_type, load, I_type, jalr, S_type, SB_type, U_type, UJ_type} = f;
  endtask

  initial begin
    // Reset cycle: strobes forced low, registers cleared.
    tick();
    chk("rst_strobes", 32'(strb), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_instret", instret, 0);
    chk("rst_flags", {30'd0, illegal, timeout}, 0);
    rst = 1'b0;

    // R-type, imem ready immediately: 0,1,2,4,0.
    set_flags(FR);
    imem_ready = 1'b1;
    #1;
    chk("r_fetch_req", {30'd0, imem_req, ir_we}, 32'h3);
    tick(); imem_ready = 1'b0; #1;
    chk("r_decode", 32'(state), 1);
    tick();
    chk("r_exec", 32'(state), 2);
    chk("r_exec_strb", 32'(strb), 0);
    tick();
    chk("r_wb", 32'(state), 4);
    chk("r_wb_strb", 32'(strb), 32'b00001110000);
    tick();
    chk("r_back_fetch", 32'(state), 0);
    chk("r_instret", instret, 1);

    // Load, dmem_ready on 4th MEM cycle (count boundary, ready wins).
    set_flags(FL);
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; #1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_wait", {28'd0, state, dmem_re}, 32'h7);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("ld_mem_last", {28'd0, state, dmem_re}, 32'h7);
    chk("ld_mem_noretire", 32'(retire), 0);
    tick(); dmem_ready = 1'b0; #1;
    chk("ld_wb_state", 32'(state), 4);
    chk("ld_wb_strb", 32'(strb), 32'b00001110001);
    tick();
    chk("ld_instret", instret, 2);
    chk("ld_no_timeout", 32'(timeout), 0);

    // Branch taken, then not taken; retire in EXEC, no rf_we.
    set_flags(FSB);
    branch_taken = 1'b1;
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; #1;
    chk("br1_decode_rf", 32'(rf_we), 0);
    tick();
    chk("br1_exec_strb", 32'(strb), 32'b00000110100);
    tick();
    chk("br1_fetch", {state, instret[28:0]}, {3'd0, 29'd3});
    branch_taken = 1'b0;
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; #1;
    tick();
    chk("br2_exec_strb", 32'(strb), 32'b00000110000);
    tick();
    chk("br2_instret", instret, 4);

    // Fetch with ready only on the 4th wait cycle: no trap.
    set_flags(FR);
    for (int i = 0; i < 3; i++) begin
      chk("fw_wait_state", 32'(state), 0);
      tick();
    end
    imem_ready = 1'b1;
    #1;
    chk("fw_last_irwe", 32'(ir_we), 1);
    tick(); imem_ready = 1'b0; #1;
    chk("fw_decode", {29'd0, state}, 1);
    tick(); tick(); tick();
    chk("fw_instret", instret, 5);
    chk("fw_no_timeout", 32'(timeout), 0);

    // Two class flags at once: illegal trap, strobes quiet until rst.
    set_flags(FR | FL);
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; #1;
    chk("ill_decode", 32'(state), 1);
    tick();
    chk("ill_trap", {28'd0, state, illegal}, 32'hB);
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("ill_trap_strb", 32'(strb), 0);
      tick();
      chk("ill_trap_hold", {28'd0, state, illegal}, 32'hB);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("ill_rst", {27'd0, state, illegal, timeout}, 0);
    chk("ill_rst_instret", instret, 0);
    rst = 1'b0;

    // imem_ready held low: trap after 4 wait cycles.
    set_flags(FR);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait", {29'd0, state}, 0);
      tick();
    end
    chk("to_trap", {27'd0, state, illegal, timeout}, 32'h15);
    chk("to_trap_strb", 32'(strb), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // instret wrap on a branch retire.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    set_flags(FSB);
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; #1;
    tick();
    chk("wrap_retire", 32'(retire), 1);
    tick();
    chk("wrap_instret", instret, 0);

    // Store retire to reach all-ones, then rst mid-MEM of the next store.
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    release dut.instret_q;
    set_flags(FS);
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; #1;
    tick();
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("st_mem_strb", 32'(strb), 32'b00100110000);
    tick(); dmem_ready = 1'b0; #1;
    chk("st_fetch", 32'(state), 0);
    chk("st_instret_ones", instret, 32'hFFFF_FFFF);
    imem_ready = 1'b1;
    tick(); imem_ready = 1'b0; #1;
    tick();
    tick();
    chk("st2_mem_we", {28'd0, state, dmem_we}, 32'h7);
    rst = 1'b1;
    #1;
    chk("st2_rst_drop", 32'(strb), 0);
    tick();
    chk("st2_rst_state", 32'(state), 0);
    chk("st2_rst_instret", instret, 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
